mmio_io_ctrl: RTL
=================

Name: mmio_io_ctrl

Overview:
Memory-mapped I/O controller on the processor data-memory bus. It replaces the fixed two-address switch/LED decode with a parametrised register block. The block provides:
- synchronised, debounced switch and button inputs;
- an LED register with write, set and clear access;
- sticky button rising-edge flags;
- a maskable interrupt.
It sits beside RAM in the top-level wrapper. The top level selects `rdata` over RAM data whenever `hit` is 1.

Parameters:
- BASE_ADDR, 4096: byte/word address of register 0; must be a multiple of 8.
- ADDR_W, 32: bus address width.
- DATA_W, 32: bus data width.
- SW_W, 16: number of switch inputs (≤ DATA_W).
- BTN_W, 5: number of button inputs (≤ DATA_W).
- LED_W, 16: number of LED outputs (≤ DATA_W).
- SYNC_STAGES, 2: synchroniser flops per input (≥ 2).
- DB_CYCLES, 250000: consecutive stable cycles before a debounced value changes (10 ms at 25 MHz).

Ports:
- clock, in, 1: sole clock.
- reset, in, 1: synchronous, active-low; 0 = reset.
- addr, in, ADDR_W: bus address.
- wren, in, 1: bus write enable.
- wdata, in, DATA_W: bus write data.
- rdata, out, DATA_W: read data for the addressed register.
- hit, out, 1: addr is within [BASE_ADDR, BASE_ADDR+7].
- sw_in, in, SW_W: raw asynchronous switches.
- btn_in, in, BTN_W: raw asynchronous buttons.
- led_out, out, LED_W: LED drive.
- irq, out, 1: level interrupt.

Behaviour:
- Reset (reset=0 at a clock edge) clears to 0:
  - all synchroniser flops and debounce counters;
  - debounced SW and BTN values;
  - LED, EDGE and MASK registers;
  - irq.
- Decode: off = addr − BASE_ADDR. hit = (addr ≥ BASE_ADDR) && (off < 8). Decode is combinational.
- Register map (by off):
  - 0 SW, RO: debounced switches, zero-extended.
  - 1 LED, RW: write LED ← wdata[LED_W-1:0].
  - 2 LED_SET, WO: LED ← LED | wdata. Reads 0.
  - 3 LED_CLR, WO: LED ← LED & ~wdata. Reads 0.
  - 4 BTN, RO: debounced buttons.
  - 5 EDGE, R/W1C: sticky rising-edge flags. Writing 1 clears the bit; writing 0 leaves it unchanged.
  - 6 MASK, RW: interrupt enable, BTN_W bits.
  - 7 reserved: reads 0, writes ignored.
- Reads:
  - rdata is combinational from register state. It is 0 when hit=0.
  - Reads have no side effects.
- Writes take effect on the clock edge where wren=1 && hit=1. Writes to RO registers are ignored.
- LED register and led_out:
  - led_out is driven directly from the LED register.
  - The LED register updates on the edge of the write and holds otherwise.
- Input path per bit:
  - SYNC_STAGES flop chain, then the debouncer.
  - The debouncer has a counter and a stable bit. If synced ≠ stable, the counter increments; otherwise the counter resets to 0.
  - When the counter reaches DB_CYCLES−1 while synced ≠ stable, stable ← synced and the counter ← 0.
  - Any glitch shorter than DB_CYCLES cycles never changes stable.
  - Total latency from a clean input step to the register bit changing = SYNC_STAGES + DB_CYCLES cycles.
- Edge detect:
  - EDGE[i] sets on the cycle debounced BTN[i] goes 0→1.
  - If a set and a W1C clear of the same bit occur on the same edge, set wins.
- irq is registered: irq ← |(EDGE_next & MASK_next). It asserts 1 cycle after the edge flag sets, and deasserts 1 cycle after the flag is cleared or masked.
- Counter width is $clog2(DB_CYCLES)+1. Counter values saturate by design; no wrap is reachable.
- Reset mid-debounce: pending counts are discarded. The stable value returns to 0 and re-qualifies from there.
- Widths narrower than DATA_W are zero-extended on read. Upper write bits are ignored.

Decomposition:
- Package mmio_io_pkg:
  - register offset constants: OFF_SW=0, OFF_LED=1, OFF_LED_SET=2, OFF_LED_CLR=3, OFF_BTN=4, OFF_EDGE=5, OFF_MASK=6;
  - NUM_REGS=8.
- Sub-module io_debounce, parameters SYNC_STAGES and DB_CYCLES:
  - a single-bit synchroniser plus debouncer, with clock and reset;
  - instantiated SW_W+BTN_W times through a generate loop.

Test Plan (DB_CYCLES=4, SYNC_STAGES=2):
1. Reset and switch read: hold reset=0 for 3 cycles, then release. Set sw_in=16'hA5A5 and wait 6 cycles. A read of addr 4096 then returns 32'h0000A5A5. Before that (cycles 1–5) it returns 0; hit=1 throughout.
2. LED write/set/clear:
   - write 4097←16'h00F0: led_out=16'h00F0 the next cycle;
   - write 4098←16'h0003: led_out=16'h00F3;
   - write 4099←16'h0030: led_out=16'h00C3;
   - read 4097: returns 32'h000000C3.
3. Glitch rejection: pulse btn_in[0]=1 for 3 cycles, then 0. BTN stays 0 and EDGE stays 0. A 10-cycle pulse gives BTN[0]=1 at cycle 6 and EDGE=32'h1.
4. W1C and interrupt:
   - MASK←1 with EDGE[0]=1: irq=1 one cycle later;
   - write 4101←32'h2 (bit 1 only): EDGE stays 1;
   - write 4101←32'h1: EDGE=0, and irq=0 one cycle later.
5. Set-beats-clear: time the W1C write of EDGE bit 2 to the exact cycle BTN[2] rises. EDGE[2]=1 afterwards.
6. Decode bounds: read addr 4095 and addr 4104 (one past the last register). Both give hit=0 and rdata=0. A write at 4103 leaves all registers unchanged. Assert reset mid-qualification (counter=2): BTN stays 0 and re-qualifies in a full 6 cycles after release.

Source files
------------

// File: rtl/mmio_io_pkg.sv
// Shared register map constants for the MMIO I/O controller.
package mmio_io_pkg;

  localparam int NUM_REGS = 8;

  localparam logic [2:0] OFF_SW      = 3'd0;
  localparam logic [2:0] OFF_LED     = 3'd1;
  localparam logic [2:0] OFF_LED_SET = 3'd2;
  localparam logic [2:0] OFF_LED_CLR = 3'd3;
  localparam logic [2:0] OFF_BTN     = 3'd4;
  localparam logic [2:0] OFF_EDGE    = 3'd5;
  localparam logic [2:0] OFF_MASK    = 3'd6;

endpackage

// File: rtl/io_debounce.sv
// Single-bit synchroniser followed by a stable-count debouncer.
module io_debounce
  import mmio_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic i_din,
  output logic o_stable
);

  localparam int CNT_W = $clog2(DB_CYCLES) + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;

  // Shift the raw input through the sync chain; count how long the synced
  // value has disagreed with stable and adopt it once the count expires.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
      if (w_synced != r_stable) begin
        if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
          r_stable <= w_synced;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped switch/button/LED register block with a maskable interrupt.
module mmio_io_ctrl
  import mmio_io_pkg::*;
#(
  parameter int BASE_ADDR   = 4096,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SW_W        = 16,
  parameter int BTN_W       = 5,
  parameter int LED_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 250000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wren,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  input  logic [SW_W-1:0]   sw_in,
  input  logic [BTN_W-1:0]  btn_in,
  output logic [LED_W-1:0]  led_out,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam int NIN = SW_W + BTN_W;

  logic [ADDR_W-1:0] w_off;
  logic [2:0]        w_sel;
  logic              w_hit;
  logic              w_wr;
  logic [NIN-1:0]    w_raw;
  logic [NIN-1:0]    w_db;
  logic [SW_W-1:0]   w_sw_db;
  logic [BTN_W-1:0]  w_btn_db;
  logic [BTN_W-1:0]  w_rise;
  logic [BTN_W-1:0]  w_w1c;
  logic [LED_W-1:0]  w_led_nxt;
  logic [BTN_W-1:0]  w_edge_nxt;
  logic [BTN_W-1:0]  w_mask_nxt;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused_wdata;

  logic [LED_W-1:0]  r_led;
  logic [BTN_W-1:0]  r_edge;
  logic [BTN_W-1:0]  r_mask;
  logic [BTN_W-1:0]  r_btn_q;
  logic              r_irq;

  // Decode: the subtraction wraps below BASE, so the >= test is kept explicit.
  assign w_off = addr - BASE;
  assign w_sel = w_off[2:0];
  assign w_hit = (addr >= BASE) && (w_off < ADDR_W'(NUM_REGS));
  assign w_wr  = wren && w_hit;

  // Only the low register-width bits of a write are meaningful.
  assign w_unused_wdata = ^wdata;

  // Switches occupy the low lanes, buttons the high lanes.
  assign w_raw    = {btn_in, sw_in};
  assign w_sw_db  = w_db[SW_W-1:0];
  assign w_btn_db = w_db[NIN-1:SW_W];

  for (genvar g = 0; g < NIN; g++) begin : g_in
    io_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_db (
      .clock    (clock),
      .reset    (reset),
      .i_din    (w_raw[g]),
      .o_stable (w_db[g])
    );
  end

  // Rising edge of the debounced button, seen in the first cycle it reads 1.
  assign w_rise = w_btn_db & ~r_btn_q;

  // Next-state for writable registers; a fresh edge overrides a same-cycle W1C.
  always_comb begin
    w_led_nxt  = r_led;
    w_mask_nxt = r_mask;
    w_w1c      = '0;
    if (w_wr) begin
      case (w_sel)
        OFF_LED:     w_led_nxt  = wdata[LED_W-1:0];
        OFF_LED_SET: w_led_nxt  = r_led | wdata[LED_W-1:0];
        OFF_LED_CLR: w_led_nxt  = r_led & ~wdata[LED_W-1:0];
        OFF_EDGE:    w_w1c      = wdata[BTN_W-1:0];
        OFF_MASK:    w_mask_nxt = wdata[BTN_W-1:0];
        default:     ;
      endcase
    end
    w_edge_nxt = (r_edge & ~w_w1c) | w_rise;
  end

  // Register state; irq looks at next-state so it tracks flags with one cycle lag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_led   <= '0;
      r_edge  <= '0;
      r_mask  <= '0;
      r_btn_q <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_led   <= w_led_nxt;
      r_edge  <= w_edge_nxt;
      r_mask  <= w_mask_nxt;
      r_btn_q <= w_btn_db;
      r_irq   <= |(w_edge_nxt & w_mask_nxt);
    end
  end

  // Read mux, zero-extended, forced to 0 off-window; write-only slots read 0.
  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_sel)
        OFF_SW:   w_rdata[SW_W-1:0]  = w_sw_db;
        OFF_LED:  w_rdata[LED_W-1:0] = r_led;
        OFF_BTN:  w_rdata[BTN_W-1:0] = w_btn_db;
        OFF_EDGE: w_rdata[BTN_W-1:0] = r_edge;
        OFF_MASK: w_rdata[BTN_W-1:0] = r_mask;
        default:  ;
      endcase
    end
  end

  assign rdata   = w_rdata;
  assign hit     = w_hit;
  assign led_out = r_led;
  assign irq     = r_irq;

endmodule
